// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, constants and the lane mask-merge helper for
//               the 1R1W memory and its clear sweep state machine.
//               Contents: rdw_mode_e (read-during-write mode encoding),
//               clr_state_e (clear sweep states), the legal READ_LATENCY
//               values, and mask_merge().
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [0:0] {
    RDW_WRITE_FIRST = 1'b0,
    RDW_READ_FIRST  = 1'b1
  } rdw_mode_e;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  localparam int c_read_lat_min = 1;
  localparam int c_read_lat_max = 2;

  // mask_merge works on a fixed wide vector so one function serves every
  // DATA_WIDTH; callers zero-extend their operands and truncate the result.
  localparam int c_merge_width = 512;
  localparam int c_merge_aw    = $clog2(c_merge_width);

  // Bit b takes new_data when its lane (b / gran) is enabled in mask.
  function automatic logic [c_merge_width-1:0] mask_merge(
    input logic [c_merge_width-1:0] old_data,
    input logic [c_merge_width-1:0] new_data,
    input logic [c_merge_width-1:0] mask,
    input int                       gran
  );
    logic [c_merge_width-1:0] merged;
    merged = old_data;
    for (int b = 0; b < c_merge_width; b++) begin
      if (mask[c_merge_aw'(b / gran)]) begin
        merged[c_merge_aw'(b)] = new_data[c_merge_aw'(b)];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_1r1w_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : memory_1r1w_clear_fsm
// Description : Post-reset clear sweep. While reset is high the sweep is
//               armed at address 0; after release one entry per cycle is
//               written to zero, addresses 0..DEPTH-1, then the FSM idles.
//               Only instantiated when MEM1R1W_CLEAR_EN is defined.
// Ports       : clock     - clock
//               reset     - synchronous active-high reset (restarts sweep)
//               clr_we    - write strobe for the zeroing write port
//               clr_addr  - address being zeroed
//               init_busy - sweep in progress (also high during reset)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_1r1w_clear_fsm
  import mem_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            r_state;
  clr_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLR_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLR_SWEEP: begin
        if (r_cnt == c_last) begin
          w_state_nxt = CLR_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset holds the sweep armed without writing; busy covers the reset
  // window too so the user ports are blocked from the first reset cycle.
  assign clr_we    = (r_state == CLR_SWEEP) && !reset;
  assign clr_addr  = r_cnt;
  assign init_busy = reset || (r_state == CLR_SWEEP);

endmodule
`default_nettype wire

// File: rtl/memory_1r1w_param.sv
`default_nettype none
// ============================================================================
// Module      : memory_1r1w_param
// Description : Parametrised 1-read/1-write synchronous memory with write
//               enable, per-lane write mask, selectable read-during-write
//               behaviour, 1- or 2-cycle read latency and a read-valid strobe.
//               Optional feature macro: MEM1R1W_CLEAR_EN (zeroing sweep of
//               the whole array after every reset, flagged by init_busy).
// Ports       : clock, reset (sync, active-high)
//               ren/raddr -> rdata/rvalid    read port
//               wen/waddr/wdata/wmask        write port (mask 1 = write lane)
//               init_busy                    clear sweep active (0 if no macro)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_1r1w_param
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MASK_GRAN    = 8,
  parameter int RDW_MODE     = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ren,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rvalid,
  input  logic                            wen,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH/MASK_GRAN-1:0] wmask,
  output logic                            init_busy
);

  // Elaboration guards for unsupported configurations.
  if ((READ_LATENCY != c_read_lat_min) && (READ_LATENCY != c_read_lat_max)) begin : g_bad_latency
    $error("memory_1r1w_param: READ_LATENCY must be 1 or 2");
  end
  if ((MASK_GRAN < 1) || ((DATA_WIDTH % MASK_GRAN) != 0)) begin : g_bad_mask
    $error("memory_1r1w_param: DATA_WIDTH must be a multiple of MASK_GRAN");
  end
  if (DATA_WIDTH > c_merge_width) begin : g_bad_width
    $error("memory_1r1w_param: DATA_WIDTH exceeds mask_merge width");
  end
  if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw
    $error("memory_1r1w_param: RDW_MODE must be 0 or 1");
  end

  localparam logic [ADDR_WIDTH:0] c_depth       = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic                c_write_first = (RDW_MODE == int'(RDW_WRITE_FIRST));

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

`ifdef MEM1R1W_CLEAR_EN
  memory_1r1w_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clock     (clock),
    .reset     (reset),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_busy (w_busy)
  );
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign init_busy = w_busy;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_raddr_ok;
  logic                  w_waddr_ok;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_rd_acc   = ren && !w_busy;
  assign w_wr_acc   = wen && !w_busy;
  assign w_raddr_ok = ({1'b0, raddr} < c_depth);
  assign w_waddr_ok = ({1'b0, waddr} < c_depth);

  // Post-write value of the addressed entry; also the write-first bypass.
  assign w_merged = DATA_WIDTH'(mask_merge(c_merge_width'(r_mem[waddr]),
                                           c_merge_width'(wdata),
                                           c_merge_width'(wmask),
                                           MASK_GRAN));

  always_comb begin
    w_rd_data = '0;
    if (w_raddr_ok) begin
      w_rd_data = r_mem[raddr];
      if (c_write_first && w_wr_acc && (waddr == raddr)) begin
        w_rd_data = w_merged;
      end
    end
  end

  // Array storage carries no reset; only the clear sweep zeroes it.
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc && w_waddr_ok) begin
      r_mem[waddr] <= w_merged;
    end
  end

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clock) begin
      if (reset) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) begin
          r_rdata <= w_rd_data;
        end
      end
    end
  end else begin : g_lat2
    logic                  r_p_valid;
    logic [DATA_WIDTH-1:0] r_p_data;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_p_valid <= 1'b0;
        r_p_data  <= '0;
        r_rvalid  <= 1'b0;
        r_rdata   <= '0;
      end else begin
        r_p_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_p_data <= w_rd_data;
        end
        r_rvalid <= r_p_valid;
        if (r_p_valid) begin
          r_rdata <= r_p_data;
        end
      end
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

endmodule
`default_nettype wire
